// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array driver.
//   state_t       : driver FSM state encoding
//   DEF_*         : default element widths, array dimensions, counter width
//   pipe_latency  : enabled cycles from an ifmap entering the array until its
//                   ofmap column vector is presented on the array output
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  localparam int DEF_IFMAP_WIDTH  = 16;
  localparam int DEF_WEIGHT_WIDTH = 16;
  localparam int DEF_OFMAP_WIDTH  = 32;
  localparam int DEF_ARRAY_HEIGHT = 4;
  localparam int DEF_ARRAY_WIDTH  = 4;
  localparam int DEF_CNT_WIDTH    = 16;

  // The skewed array needs one enabled cycle per row to ripple an ifmap
  // across and one per column to deskew the partial sums on the way out.
  function automatic int pipe_latency(input int height, input int width);
    return height + width;
  endfunction

endpackage

// File: rtl/valid_tag_pipe.sv
// Shift register of 1-bit tags that shadows the systolic array pipeline.
// A 1 marks a real ifmap, a 0 marks a bubble; the tag leaving the last stage
// tells the driver whether the array output in that cycle is a real result.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear of all stages
//   en         : advance the pipeline by one stage
//   din        : tag entering stage 0
//   dout       : tag in the last stage
//   occupied   : any stage holds a 1
module valid_tag_pipe #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic dout,
  output logic occupied
);

  logic [DEPTH-1:0] tag_p;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      tag_p <= '0;
    end else if (en) begin
      tag_p <= {tag_p[DEPTH-2:0], din};
    end
  end

  assign dout     = tag_p[DEPTH-1];
  assign occupied = |tag_p;

endmodule

// File: rtl/systolic_array_driver.sv
// Initiator-side sequencer for a systolic_array_with_skew instance.
// Loads ARRAY_HEIGHT weight rows, streams num_vectors ifmap vectors through
// the array, and returns each finished ofmap vector on a valid/ready stream.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start, num_vectors  : job launch pulse and vector count (sampled on start)
//   busy, done          : job in progress, one-cycle completion pulse
//   w_valid/w_ready/w_data : weight row stream, rows in order 0..H-1
//   i_valid/i_ready/i_data : ifmap vector stream
//   o_valid/o_ready/o_data : ofmap vector stream
//   sa_*                : connections to the systolic array
module systolic_array_driver
  import systolic_pkg::*;
#(
  parameter int IFMAP_WIDTH  = DEF_IFMAP_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int OFMAP_WIDTH  = DEF_OFMAP_WIDTH,
  parameter int ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
  parameter int ARRAY_WIDTH  = DEF_ARRAY_WIDTH,
  parameter int PIPE_LATENCY = pipe_latency(ARRAY_HEIGHT, ARRAY_WIDTH),
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [CNT_WIDTH-1:0]                     num_vectors,
  output logic                                     busy,
  output logic                                     done,
  input  logic                                     w_valid,
  output logic                                     w_ready,
  input  logic [ARRAY_WIDTH-1:0][WEIGHT_WIDTH-1:0] w_data,
  input  logic                                     i_valid,
  output logic                                     i_ready,
  input  logic [ARRAY_HEIGHT-1:0][IFMAP_WIDTH-1:0] i_data,
  output logic                                     o_valid,
  input  logic                                     o_ready,
  output logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0]  o_data,
  output logic                                     sa_en,
  output logic                                     sa_weight_en,
  output logic [ARRAY_HEIGHT-1:0]                  sa_weight_wen,
  output logic [ARRAY_WIDTH-1:0][WEIGHT_WIDTH-1:0] sa_weight_in,
  output logic [ARRAY_HEIGHT-1:0][IFMAP_WIDTH-1:0] sa_ifmap_in,
  output logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0]  sa_ofmap_in,
  input  logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0]  sa_ofmap_out
);

  localparam int ROW_W = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;

  state_t               state;
  logic [ROW_W-1:0]     row_cnt;
  logic [CNT_WIDTH-1:0] vec_cnt;
  logic [CNT_WIDTH-1:0] num_q;

  logic active;
  logic stall;
  logic w_hs;
  logic i_hs;
  logic capture;
  logic last_row;
  logic last_vec;
  logic pipe_clr;
  logic tag_out;
  logic pipe_occupied;

  // ------------------------------------------------------------------
  // Handshakes and array control
  // ------------------------------------------------------------------
  assign active   = (state == S_STREAM) || (state == S_DRAIN);

  // Only a real result that cannot be handed over freezes the array; a
  // bubble at the output is simply dropped, so it never blocks progress.
  assign stall    = o_valid & ~o_ready & tag_out;

  assign w_ready  = (state == S_LOAD_W);
  assign w_hs     = w_valid & w_ready;
  assign i_ready  = (state == S_STREAM) & ~stall;
  assign i_hs     = i_valid & i_ready;
  assign sa_en    = active & ~stall;
  assign capture  = active & tag_out & ~stall;

  assign last_row = (row_cnt == ROW_W'(ARRAY_HEIGHT - 1));
  assign last_vec = (vec_cnt + CNT_WIDTH'(1)) == num_q;

  assign busy         = (state != S_IDLE);
  assign sa_weight_en = (state == S_LOAD_W);
  assign sa_weight_in = w_hs ? w_data : '0;
  assign sa_ifmap_in  = i_hs ? i_data : '0;
  assign sa_ofmap_in  = '0;

  always_comb begin
    sa_weight_wen = '0;
    if (w_hs) begin
      sa_weight_wen[row_cnt] = 1'b1;
    end
  end

  // Stale tags from an earlier job must never produce an output.
  assign pipe_clr = (state == S_IDLE) & start;

  valid_tag_pipe #(
    .DEPTH (PIPE_LATENCY)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pipe_clr),
    .en       (sa_en),
    .din      (i_hs),
    .dout     (tag_out),
    .occupied (pipe_occupied)
  );

  // ------------------------------------------------------------------
  // Sequencer and output register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      row_cnt <= '0;
      vec_cnt <= '0;
      num_q   <= '0;
      done    <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      done <= 1'b0;

      // Capture may coincide with the consumer taking the previous result,
      // which keeps one result per cycle flowing.
      if (capture) begin
        o_valid <= 1'b1;
        o_data  <= sa_ofmap_out;
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            num_q   <= num_vectors;
            row_cnt <= '0;
            vec_cnt <= '0;
            state   <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (w_hs) begin
            if (last_row) begin
              row_cnt <= '0;
              if (num_q == '0) begin
                state <= S_FLUSH;
                done  <= 1'b1;
              end else begin
                state <= S_STREAM;
              end
            end else begin
              row_cnt <= row_cnt + ROW_W'(1);
            end
          end
        end
        S_STREAM: begin
          if (i_hs) begin
            vec_cnt <= vec_cnt + CNT_WIDTH'(1);
            if (last_vec) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Finish only after the last real result has left the block.
          if (!pipe_occupied && (!o_valid || o_ready)) begin
            state <= S_FLUSH;
            done  <= 1'b1;
          end
        end
        S_FLUSH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/systolic_array_driver.md
Name: systolic_array_driver

Overview:
- Initiator-side sequencer that feeds a `systolic_array_with_skew` instance and collects its results.
- Accepts weight rows and ifmap vectors over valid/ready streams, then drives the array's `weight_en`, `weight_wen`, `en`, `ifmap_in`, `weight_in` and `ofmap_in` ports.
- Returns each finished ofmap vector on a valid/ready output stream.
- Replaces hand-sequenced stimulus with an RTL front end for the accelerator datapath.

Parameters:
- IFMAP_WIDTH, 16, ifmap element width
- WEIGHT_WIDTH, 16, weight element width
- OFMAP_WIDTH, 32, partial-sum/ofmap element width
- ARRAY_HEIGHT, 4, array rows (ifmap vector length, number of weight rows)
- ARRAY_WIDTH, 4, array columns (weight row length, ofmap vector length)
- PIPE_LATENCY, ARRAY_HEIGHT+ARRAY_WIDTH, enabled cycles from ifmap acceptance to matching valid `ofmap_out`
- CNT_WIDTH, 16, width of vector-count fields

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a job from IDLE
- num_vectors  in  CNT_WIDTH  ifmap vectors in job; sampled on start; 0 is legal
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the last ofmap has been accepted
- w_valid / w_ready  in / out  1 each  weight row handshake
- w_data  in  WEIGHT_WIDTH x ARRAY_WIDTH  weight row; rows arrive in order 0..ARRAY_HEIGHT-1
- i_valid / i_ready  in / out  1 each  ifmap vector handshake
- i_data  in  IFMAP_WIDTH x ARRAY_HEIGHT  ifmap vector
- o_valid / o_ready  out / in  1 each  ofmap handshake
- o_data  out  OFMAP_WIDTH x ARRAY_WIDTH  ofmap vector
- sa_en, sa_weight_en  out  1 each  to array
- sa_weight_wen  out  1 x ARRAY_HEIGHT  one-hot row write enable
- sa_weight_in  out  WEIGHT_WIDTH x ARRAY_WIDTH  to array
- sa_ifmap_in  out  IFMAP_WIDTH x ARRAY_HEIGHT  to array
- sa_ofmap_in  out  OFMAP_WIDTH x ARRAY_WIDTH  constant 0
- sa_ofmap_out  in  OFMAP_WIDTH x ARRAY_WIDTH  from array

Behaviour:
- Reset state: IDLE. Every output and every internal counter is 0, and the tag pipeline is cleared. `sa_ofmap_in` is always 0.
- A reset mid-job aborts the job. Array contents are don't-care after reset.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, FLUSH.
- IDLE -> LOAD_W on `start`. While busy, `start` is ignored.
- LOAD_W:
  - `w_ready`=1 and `sa_weight_en`=1.
  - On each w handshake, the row counter r selects the row: `sa_weight_wen`[r]=1 (all other bits 0) and `sa_weight_in`=`w_data` in the same cycle.
  - When no handshake occurs, `sa_weight_wen` is all 0.
  - After row ARRAY_HEIGHT-1 is accepted: go to STREAM, or to FLUSH if `num_vectors`==0.
- STREAM:
  - `i_ready` = !stall. `sa_ifmap_in` = `i_data` on a handshake, otherwise 0.
  - Each stream cycle is one of two kinds:
    - Handshake cycle: `sa_en`=1 and a 1 is pushed into the tag pipeline.
    - Non-handshake cycle with stall=0: `sa_en`=1 and a bubble (0) is pushed.
  - When the accepted-vector counter reaches `num_vectors`, go to DRAIN.
- DRAIN: `sa_en`=1 whenever stall=0, with ifmap zeros and bubble tags. Go to FLUSH once the tag pipeline is empty and no ofmap is pending.
- FLUSH: `sa_weight_en`=0. Pulse `done` for one cycle, then return to IDLE.
- Tag pipeline: PIPE_LATENCY-deep shift register of 1-bit tags, advancing only when `sa_en`=1.
  - When the tag leaving the pipeline is 1, `sa_ofmap_out` is captured into the output register and `o_valid` is set.
- Stall rule:
  - stall = `o_valid` & !`o_ready` & (the outgoing tag is 1).
  - While stalled, `sa_en`=0 and the array plus the tag pipeline hold state. The array holds all internal state, including skew registers, when `en`=0.
- Output:
  - `o_valid` and `o_data` remain stable until `o_ready`.
  - A new capture and acceptance of the old result in the same cycle are allowed, so the block sustains one result per cycle.
- Arithmetic: the block performs none. Data pass through unchanged (signed).

Decomposition:
- Shared package `systolic_pkg`: FSM state encoding, default widths and dimensions, and a `PIPE_LATENCY` helper function.
- One sub-module: `valid_tag_pipe`, a parameterised shift register with enable, occupancy flag and a synchronous clear.

Test Plan:
- Weight load: rows {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16} -> `sa_weight_wen` sequences 0001, 0010, 0100, 1000, one per handshake, with `sa_weight_in` matching `w_data`.
- Stream: `num_vectors`=4, ifmaps {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}, `o_ready`=1 -> first `o_valid` at PIPE_LATENCY(=8) enabled cycles after the first i handshake, with `o_data`={90,100,110,120}. Then {202,228,254,280}, {314,356,398,440}, {426,484,542,600} on consecutive cycles, then `done`.
- Backpressure: same job with `o_ready`=0 for 5 cycles while the first result is valid -> `sa_en` low during the stall, `o_data` held, and no result lost or duplicated.
- Input bubbles: `i_valid` toggled 1,0,1,0 -> exactly 4 `o_valid` beats with correct values, and bubble tags never produce `o_valid`.
- Edge cases:
  - `num_vectors`=0 -> 4 weight rows accepted, then `done` with no `o_valid`.
  - `start` while busy -> ignored.
- Reset mid-STREAM: `rst_n`=0 for 1 cycle -> all outputs 0 and IDLE. A following full job produces correct results.
